packet_queue: RTL and testbench

//   Parametrised successor to the fixed 16/16/32 packet pass-through.

---
 rtl/packet_queue_if.sv | 41 ++++
 rtl/packet_queue.sv | 120 ++++++++++++
 tb/tb_packet_queue.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : packet_queue_if
// Description : Producer-side and consumer-side valid/ready packet handshake
//               bundle for packet_queue. Each packet is a header, an address
//               and a data field.
// Revision    : 1.0 - initial release
// ============================================================================
interface packet_queue_if #(
  parameter int HEADER_W = 16,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
);
  logic                inPacket_tx_valid;
  logic                inPacket_tx_ready;
  logic [HEADER_W-1:0] inPacket_tx_header;
  logic [ADDR_W-1:0]   inPacket_tx_addr;
  logic [DATA_W-1:0]   inPacket_tx_data;
  logic                outPacket_rx_valid;
  logic                outPacket_rx_ready;
  logic [HEADER_W-1:0] outPacket_rx_header;
  logic [ADDR_W-1:0]   outPacket_rx_addr;
  logic [DATA_W-1:0]   outPacket_rx_data;

  // Environment view: drives incoming packets and the consumer ready.
  modport master (
    output inPacket_tx_valid, inPacket_tx_header, inPacket_tx_addr, inPacket_tx_data,
    input  inPacket_tx_ready,
    input  outPacket_rx_valid, outPacket_rx_header, outPacket_rx_addr, outPacket_rx_data,
    output outPacket_rx_ready
  );

  // Queue view.
  modport slave (
    input  inPacket_tx_valid, inPacket_tx_header, inPacket_tx_addr, inPacket_tx_data,
    output inPacket_tx_ready,
    output outPacket_rx_valid, outPacket_rx_header, outPacket_rx_addr, outPacket_rx_data,
    input  outPacket_rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/packet_queue.sv
`default_nettype none
// ============================================================================
// Module      : packet_queue
// Description : DEPTH-entry FIFO for header/addr/data packets with valid/ready
//               on both sides, synchronous flush and optional flow-through
//               bypass when empty (FLOW=1).
// Revision    : 1.0 - initial release
// ============================================================================
module packet_queue #(
  parameter int HEADER_W = 16,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int FLOW     = 0
) (
  input  wire                              clock,
  input  wire                              reset,
  input  wire                              flush,
  packet_queue_if.slave                    pkt,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = HEADER_W + ADDR_W + DATA_W;

  localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
  localparam logic [PW-1:0] c_lastPtr = PW'(DEPTH - 1);

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_txReady;
  logic          w_rxValid;
  logic          w_offer;
  logic          w_bypass;
  logic          w_enq;
  logic          w_deq;
  logic          w_passThru;
  logic          w_store;
  logic          w_pop;
  logic [EW-1:0] w_inWord;
  logic [EW-1:0] w_head;
  logic [EW-1:0] w_headMasked;

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // Flow-through lets an offered packet stand in for the empty head.
  generate
    if (FLOW != 0) begin : g_flow
      assign w_offer  = pkt.inPacket_tx_valid;
      assign w_bypass = w_empty;
    end else begin : g_noFlow
      assign w_offer  = 1'b0;
      assign w_bypass = 1'b0;
    end
  endgenerate

  // Ready depends only on stored state and flush, never on the consumer.
  assign w_txReady = ~w_full & ~flush;
  assign w_rxValid = (~w_empty | w_offer) & ~flush;

  assign w_enq = pkt.inPacket_tx_valid & w_txReady;
  assign w_deq = w_rxValid & pkt.outPacket_rx_ready;

  // A packet taken straight through an empty flow-through queue is never stored.
  assign w_passThru = w_bypass & w_enq & w_deq;
  assign w_store    = w_enq & ~w_passThru;
  assign w_pop      = w_deq & ~w_passThru;

  assign w_inWord     = {pkt.inPacket_tx_header, pkt.inPacket_tx_addr, pkt.inPacket_tx_data};
  assign w_head       = w_bypass ? w_inWord : r_mem[r_rdPtr];
  assign w_headMasked = w_rxValid ? w_head : '0;

  assign pkt.inPacket_tx_ready   = w_txReady;
  assign pkt.outPacket_rx_valid  = w_rxValid;
  assign pkt.outPacket_rx_header = w_headMasked[EW-1 -: HEADER_W];
  assign pkt.outPacket_rx_addr   = w_headMasked[DATA_W +: ADDR_W];
  assign pkt.outPacket_rx_data   = w_headMasked[DATA_W-1:0];
  assign count                   = r_count;

  // Pointer and occupancy bookkeeping; flush empties the queue on the next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_wrPtr <= (r_wrPtr == c_lastPtr) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == c_lastPtr) ? '0 : r_rdPtr + PW'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (w_store) begin
      r_mem[r_wrPtr] <= w_inWord;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_packet_queue
// Description : Drives three packet_queue configurations (DEPTH 4/FLOW 0,
//               DEPTH 3/FLOW 0, DEPTH 4/FLOW 1) from shared stimulus and
//               compares every output each cycle to an array-based FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        txValid;
  logic        rxReady;
  logic [15:0] hdr;
  logic [15:0] addr;
  logic [31:0] data;

  int nChecks = 0;
  int nFails  = 0;

  logic [63:0] mdl [3][8];
  int          msize [3];
  logic        lastEnq [3];

  logic        obsTxReady [3];
  logic        obsRxValid [3];
  logic [63:0] obsHead [3];
  logic [7:0]  obsCount [3];

  logic [2:0] count0;
  logic [1:0] count1;
  logic [2:0] count2;

  always #5 clk = ~clk;

  packet_queue_if #(.HEADER_W(16), .ADDR_W(16), .DATA_W(32)) bus0 ();
  packet_queue_if #(.HEADER_W(16), .ADDR_W(16), .DATA_W(32)) bus1 ();
  packet_queue_if #(.HEADER_W(16), .ADDR_W(16), .DATA_W(32)) bus2 ();

  packet_queue #(.HEADER_W(16), .ADDR_W(16), .DATA_W(32), .DEPTH(4), .FLOW(0)) dut0 (
    .clock(clk), .reset(reset), .flush(flush), .pkt(bus0.slave), .count(count0));
  packet_queue #(.HEADER_W(16), .ADDR_W(16), .DATA_W(32), .DEPTH(3), .FLOW(0)) dut1 (
    .clock(clk), .reset(reset), .flush(flush), .pkt(bus1.slave), .count(count1));
  packet_queue #(.HEADER_W(16), .ADDR_W(16), .DATA_W(32), .DEPTH(4), .FLOW(1)) dut2 (
    .clock(clk), .reset(reset), .flush(flush), .pkt(bus2.slave), .count(count2));

  assign bus0.inPacket_tx_valid = txValid;  assign bus0.outPacket_rx_ready = rxReady;
  assign bus0.inPacket_tx_header = hdr;     assign bus0.inPacket_tx_addr = addr;
  assign bus0.inPacket_tx_data = data;
  assign bus1.inPacket_tx_valid = txValid;  assign bus1.outPacket_rx_ready = rxReady;
  assign bus1.inPacket_tx_header = hdr;     assign bus1.inPacket_tx_addr = addr;
  assign bus1.inPacket_tx_data = data;
  assign bus2.inPacket_tx_valid = txValid;  assign bus2.outPacket_rx_ready = rxReady;
  assign bus2.inPacket_tx_header = hdr;     assign bus2.inPacket_tx_addr = addr;
  assign bus2.inPacket_tx_data = data;

  assign obsTxReady[0] = bus0.inPacket_tx_ready;
  assign obsTxReady[1] = bus1.inPacket_tx_ready;
  assign obsTxReady[2] = bus2.inPacket_tx_ready;
  assign obsRxValid[0] = bus0.outPacket_rx_valid;
  assign obsRxValid[1] = bus1.outPacket_rx_valid;
  assign obsRxValid[2] = bus2.outPacket_rx_valid;
  assign obsHead[0] = {bus0.outPacket_rx_header, bus0.outPacket_rx_addr, bus0.outPacket_rx_data};
  assign obsHead[1] = {bus1.outPacket_rx_header, bus1.outPacket_rx_addr, bus1.outPacket_rx_data};
  assign obsHead[2] = {bus2.outPacket_rx_header, bus2.outPacket_rx_addr, bus2.outPacket_rx_data};
  assign obsCount[0] = {5'd0, count0};
  assign obsCount[1] = {6'd0, count1};
  assign obsCount[2] = {5'd0, count2};

  function automatic int depthOf(input int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic bit flowOf(input int k);
    return (k == 2);
  endfunction

  // Reference behaviour: ready when not full, valid when holding something
  // (or, in flow-through, when a packet is being offered); flush blocks both.
  function automatic bit expReady(input int k);
    return (msize[k] != depthOf(k)) && !flush;
  endfunction

  function automatic bit expValid(input int k);
    return ((msize[k] != 0) || (flowOf(k) && txValid)) && !flush;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic [63:0] inWord;
    logic [63:0] head;
    inWord = {hdr, addr, data};
    for (int k = 0; k < 3; k++) begin
      if (!expValid(k))        head = '0;
      else if (msize[k] != 0)  head = mdl[k][0];
      else                     head = inWord;
      checkVal($sformatf("dut%0d txReady", k), {63'd0, obsTxReady[k]}, {63'd0, expReady(k)});
      checkVal($sformatf("dut%0d rxValid", k), {63'd0, obsRxValid[k]}, {63'd0, expValid(k)});
      checkVal($sformatf("dut%0d head", k), obsHead[k], head);
      checkVal($sformatf("dut%0d count", k), {56'd0, obsCount[k]}, 64'(msize[k]));
    end
  endtask

  task automatic modelUpdate();
    bit enq;
    bit deq;
    bit byp;
    for (int k = 0; k < 3; k++) begin
      enq = txValid && expReady(k);
      deq = expValid(k) && rxReady;
      lastEnq[k] = enq;
      if (flush) begin
        msize[k] = 0;
      end else begin
        byp = deq && (msize[k] == 0);
        if (deq && msize[k] > 0) begin
          for (int i = 0; i < 7; i++) mdl[k][i] = mdl[k][i+1];
          msize[k]--;
        end
        if (enq && !byp) begin
          mdl[k][msize[k]] = {hdr, addr, data};
          msize[k]++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkAll();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] h, input logic [31:0] d);
    txValid = 1'b1;
    hdr     = h;
    addr    = 16'($urandom);
    data    = d;
  endtask

  initial begin
    int idx;
    reset   = 1'b1;
    flush   = 1'b0;
    txValid = 1'b0;
    rxReady = 1'b0;
    hdr     = '0;
    addr    = '0;
    data    = '0;
    for (int k = 0; k < 3; k++) begin
      msize[k]   = 0;
      lastEnq[k] = 1'b0;
    end

    // Reset state.
    #7;
    checkAll();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill with headers 1..4 while the consumer stalls.
    for (int i = 1; i <= 4; i++) begin
      offer(16'(i), $urandom);
      cycle();
    end
    txValid = 1'b0;
    cycle();

    // Full queue with a simultaneous dequeue refuses the input, then enq+deq.
    offer(16'h0005, 32'h5555_0005);
    rxReady = 1'b1;
    cycle();
    offer(16'h0006, 32'h6666_0006);
    cycle();
    txValid = 1'b0;
    repeat (5) cycle();

    // Asynchronous reset with three packets queued.
    rxReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(16'h0010 + 16'(i), $urandom);
      cycle();
    end
    txValid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) msize[k] = 0;
    checkAll();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ten packets through the depth-3 queue with the consumer toggling.
    idx = 0;
    for (int n = 0; n < 80 && idx < 10; n++) begin
      if (!txValid || lastEnq[1]) offer(16'h0100 + 16'(idx), 32'hA0 + 32'(idx));
      rxReady = n[0];
      cycle();
      if (lastEnq[1]) idx++;
    end
    checkVal("wrap packets accepted", 64'(idx), 64'd10);
    txValid = 1'b0;
    rxReady = 1'b1;
    repeat (6) cycle();

    // Flow-through on an empty queue.
    offer(16'h0BEE, 32'hDEADBEEF);
    rxReady = 1'b1;
    cycle();
    txValid = 1'b0;
    repeat (3) cycle();

    // Flush with two entries stored and a packet on offer.
    rxReady = 1'b0;
    offer(16'h0021, 32'h2100_0001);
    cycle();
    offer(16'h0022, 32'h2200_0002);
    cycle();
    offer(16'h0023, 32'h2300_0003);
    flush = 1'b1;
    cycle();
    flush   = 1'b0;
    txValid = 1'b0;
    cycle();

    // Random traffic; fields stay stable while an offer is pending.
    txValid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!txValid || lastEnq[0]) begin
        hdr     = 16'($urandom);
        addr    = 16'($urandom);
        data    = $urandom;
        txValid = ($urandom_range(0, 3) != 0);
      end
      rxReady = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 63) == 0);
      cycle();
    end
    flush   = 1'b0;
    txValid = 1'b0;
    rxReady = 1'b1;
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
